// File: rtl/serial_pkg.sv
// Shared serial framing definitions: FSM state encoding and frame field widths.
// The matching transmitter reuses these so both ends agree on the frame layout.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   localparam int MAX_DATA_W = 16;
   localparam int START_W    = 1;
   localparam int PARITY_W   = 1;
   localparam int STOP_W     = 1;
   localparam int CNT_W      = $clog2(MAX_DATA_W + 1);

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   function automatic int frame_bits(input int data_w);
      return START_W + data_w + PARITY_W + STOP_W;
   endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial bit input plus received-word output bus of the parity receiver.
// Master drives the line and the ready; slave is the receiver.
interface serial_parity_rx_if #(
   parameter int DATA_W = 8
);
   logic              bit_valid;
   logic              bit_in;
   logic              out_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              overrun;

   modport master (
      output bit_valid, bit_in, out_ready,
      input  data_out, data_valid, parity_err, frame_err, overrun
   );

   modport slave (
      input  bit_valid, bit_in, out_ready,
      output data_out, data_valid, parity_err, frame_err, overrun
   );
endinterface

// File: rtl/parity_acc.sv
// One-bit XOR accumulator with synchronous clear and enable.
// Clear wins over enable so a new frame always starts from zero.
module parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);
   logic x;

   xor u_xor (x, q, d);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         q <= 1'b0;
      end else if (en) begin
         q <= x;
      end
   end
endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop; single holding register.
// Word appears one cycle after the stop bit; a frame arriving while the word is still held and not taken is dropped and flagged.
module serial_parity_rx
   import serial_pkg::*;
#(
   parameter bit ODD_PARITY = 1'b0,
   parameter int DATA_W     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_parity_rx_if.slave   bus
);
   rx_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_q;
   logic              cnt_clr, shift_en, par_clr, par_en, frame_done;
   logic              last_data, load, drop;

   logic [DATA_W-1:0] dat_q;
   logic              vld_q, perr_q, ferr_q, ovr_q;

   assign last_data = (cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Nothing advances without a bit strobe.
   always_comb begin
      state_nxt  = state;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      par_clr    = 1'b0;
      par_en     = 1'b0;
      frame_done = 1'b0;
      if (bus.bit_valid) begin
         case (state)
            ST_IDLE: begin
               if (bus.bit_in == START_BIT) begin
                  state_nxt = ST_DATA;
                  cnt_clr   = 1'b1;
                  par_clr   = 1'b1;
               end
            end
            ST_DATA: begin
               shift_en = 1'b1;
               par_en   = 1'b1;
               if (last_data) begin
                  state_nxt = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_en    = 1'b1;
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               frame_done = 1'b1;
               state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         cnt <= '0;
      end else if (shift_en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Right shift in at the MSB so the first data bit ends up at the LSB.
   generate
      if (DATA_W == 1) begin : g_shift1
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               shreg <= '0;
            end else if (shift_en) begin
               shreg <= bus.bit_in;
            end
         end
      end else begin : g_shiftn
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               shreg <= '0;
            end else if (shift_en) begin
               shreg <= {bus.bit_in, shreg[DATA_W-1:1]};
            end
         end
      end
   endgenerate

   parity_acc u_parity_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (par_clr),
      .en    (par_en),
      .d     (bus.bit_in),
      .q     (par_q)
   );

   assign load = frame_done && (!vld_q || bus.out_ready);
   assign drop = frame_done && vld_q && !bus.out_ready;

   // par_q already folds in the parity bit by the time the stop bit arrives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dat_q  <= '0;
         vld_q  <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (load) begin
            dat_q  <= shreg;
            perr_q <= (par_q != ODD_PARITY);
            ferr_q <= (bus.bit_in != STOP_BIT);
            vld_q  <= 1'b1;
         end else if (vld_q && bus.out_ready) begin
            vld_q <= 1'b0;
         end
         if (drop) begin
            ovr_q <= 1'b1;
         end
      end
   end

   assign bus.data_out   = dat_q;
   assign bus.data_valid = vld_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an even and an odd parity receiver share one serial line
// and are compared against directed expectations and a frame-level reference model.
module tb_serial_parity_rx;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          bv = 1'b0;
   logic          bi = 1'b1;
   logic          rdy = 1'b0;
   logic          rnd_rdy = 1'b0;
   logic          stop_now = 1'b0;
   logic [DW-1:0] exp_word = '0;
   logic          exp_par_total = 1'b0;
   logic          exp_ferr = 1'b0;
   logic          drv_done = 1'b0;

   int total = 0;
   int bad = 0;

   serial_parity_rx_if #(.DATA_W(DW)) if0 ();
   serial_parity_rx_if #(.DATA_W(DW)) if1 ();

   assign if0.bit_valid = bv;
   assign if0.bit_in    = bi;
   assign if0.out_ready = rdy;
   assign if1.bit_valid = bv;
   assign if1.bit_in    = bi;
   assign if1.out_ready = rdy;

   serial_parity_rx #(.ODD_PARITY(1'b0), .DATA_W(DW)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   serial_parity_rx #(.ODD_PARITY(1'b1), .DATA_W(DW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   logic [DW-1:0] o_dat [2];
   logic          o_vld [2];
   logic          o_perr[2];
   logic          o_ferr[2];
   logic          o_ovr [2];

   assign o_dat[0]  = if0.data_out;   assign o_dat[1]  = if1.data_out;
   assign o_vld[0]  = if0.data_valid; assign o_vld[1]  = if1.data_valid;
   assign o_perr[0] = if0.parity_err; assign o_perr[1] = if1.parity_err;
   assign o_ferr[0] = if0.frame_err;  assign o_ferr[1] = if1.frame_err;
   assign o_ovr[0]  = if0.overrun;    assign o_ovr[1]  = if1.overrun;

   // Reference: one held word per receiver; the driver announces each completed frame
   // with its arithmetic expectations, dut index 1 expects odd total parity.
   logic [DW-1:0] m_dat [2];
   logic          m_vld [2];
   logic          m_perr[2];
   logic          m_ferr[2];
   logic          m_ovr [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_dat[k] <= '0; m_vld[k] <= 1'b0; m_perr[k] <= 1'b0; m_ferr[k] <= 1'b0; m_ovr[k] <= 1'b0;
         end else if (bv && stop_now) begin
            if (!m_vld[k] || rdy) begin
               m_dat[k]  <= exp_word;
               m_vld[k]  <= 1'b1;
               m_perr[k] <= (exp_par_total != (k == 1));
               m_ferr[k] <= exp_ferr;
            end else begin
               m_ovr[k] <= 1'b1;
            end
         end else if (m_vld[k] && rdy) begin
            m_vld[k] <= 1'b0;
         end
      end
   end

   // Words actually handed over by the even-parity receiver.
   logic [DW+1:0] seen[$];
   always @(negedge clk) begin
      if (rst_n && o_vld[0] && rdy) seen.push_back({o_perr[0], o_ferr[0], o_dat[0]});
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_bit(input logic b);
      bv = 1'b1;
      bi = b;
      tick();
      bv = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] w, input logic pbit, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DW; i++) drive_bit(w[i]);
      drive_bit(pbit);
      exp_word      = w;
      exp_par_total = (($countones(w) + int'(pbit)) % 2) == 1;
      exp_ferr      = !stop;
      stop_now      = 1'b1;
      drive_bit(stop);
      stop_now      = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bv    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++; if (o_vld[k] !== 1'b0) begin bad++; $display("FAIL reset_vld dut%0d got=%b exp=0", k, o_vld[k]); end
         total++; if (o_dat[k] !== 8'h00) begin bad++; $display("FAIL reset_dat dut%0d got=%h exp=00", k, o_dat[k]); end
         total++; if (o_perr[k] !== 1'b0) begin bad++; $display("FAIL reset_perr dut%0d got=%b exp=0", k, o_perr[k]); end
         total++; if (o_ferr[k] !== 1'b0) begin bad++; $display("FAIL reset_ferr dut%0d got=%b exp=0", k, o_ferr[k]); end
         total++; if (o_ovr[k] !== 1'b0) begin bad++; $display("FAIL reset_ovr dut%0d got=%b exp=0", k, o_ovr[k]); end
      end
   endtask

   task automatic test_even_frame();
      rdy = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++; if (o_vld[k] !== 1'b1) begin bad++; $display("FAIL even_vld dut%0d got=%b exp=1", k, o_vld[k]); end
         total++; if (o_dat[k] !== 8'hA5) begin bad++; $display("FAIL even_dat dut%0d got=%h exp=a5", k, o_dat[k]); end
         total++; if (o_ferr[k] !== 1'b0) begin bad++; $display("FAIL even_ferr dut%0d got=%b exp=0", k, o_ferr[k]); end
      end
      total++; if (o_perr[0] !== 1'b0) begin bad++; $display("FAIL even_perr_even got=%b exp=0", o_perr[0]); end
      total++; if (o_perr[1] !== 1'b1) begin bad++; $display("FAIL even_perr_odd got=%b exp=1", o_perr[1]); end
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      @(negedge clk);
      total++; if (o_vld[0] !== 1'b0) begin bad++; $display("FAIL even_drain got=%b exp=0", o_vld[0]); end
   endtask

   task automatic test_parity();
      rdy = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1);
      @(negedge clk);
      total++; if (o_dat[0] !== 8'hA5) begin bad++; $display("FAIL par_dat got=%h exp=a5", o_dat[0]); end
      total++; if (o_perr[0] !== 1'b1) begin bad++; $display("FAIL par_err_even got=%b exp=1", o_perr[0]); end
      total++; if (o_perr[1] !== 1'b0) begin bad++; $display("FAIL par_err_odd got=%b exp=0", o_perr[1]); end
      rdy = 1'b1;
      tick();
   endtask

   task automatic test_frame_err();
      rdy = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b0);
      @(negedge clk);
      total++; if (o_vld[0] !== 1'b1) begin bad++; $display("FAIL ferr_vld got=%b exp=1", o_vld[0]); end
      total++; if (o_dat[0] !== 8'h3C) begin bad++; $display("FAIL ferr_dat got=%h exp=3c", o_dat[0]); end
      total++; if (o_ferr[0] !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", o_ferr[0]); end
      drive_bit(1'b1);
      send_frame(8'h01, 1'b1, 1'b1);
      @(negedge clk);
      total++; if (o_vld[0] !== 1'b1) begin bad++; $display("FAIL ferr_next_vld got=%b exp=1", o_vld[0]); end
      total++; if (o_dat[0] !== 8'h01) begin bad++; $display("FAIL ferr_next_dat got=%h exp=01", o_dat[0]); end
      total++; if (o_ferr[0] !== 1'b0) begin bad++; $display("FAIL ferr_next_ferr got=%b exp=0", o_ferr[0]); end
      total++; if (o_perr[0] !== 1'b0) begin bad++; $display("FAIL ferr_next_perr got=%b exp=0", o_perr[0]); end
      tick();
   endtask

   task automatic test_overrun();
      do_reset();
      rdy = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++; if (o_dat[k] !== 8'h11) begin bad++; $display("FAIL ovr_dat dut%0d got=%h exp=11", k, o_dat[k]); end
         total++; if (o_vld[k] !== 1'b1) begin bad++; $display("FAIL ovr_vld dut%0d got=%b exp=1", k, o_vld[k]); end
         total++; if (o_ovr[k] !== 1'b1) begin bad++; $display("FAIL ovr_flag dut%0d got=%b exp=1", k, o_ovr[k]); end
      end
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      total++; if (o_vld[0] !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", o_vld[0]); end
      total++; if (o_ovr[0] !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", o_ovr[0]); end
   endtask

   task automatic test_reset_midframe();
      rdy = 1'b1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (o_vld[0] !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b exp=0", o_vld[0]); end
      total++; if (o_ovr[0] !== 1'b0) begin bad++; $display("FAIL midrst_ovr got=%b exp=0", o_ovr[0]); end
      seen.delete();
      send_frame(8'h5A, 1'b0, 1'b1);
      @(negedge clk);
      total++; if (o_dat[0] !== 8'h5A) begin bad++; $display("FAIL midrst_dat got=%h exp=5a", o_dat[0]); end
      total++; if (o_vld[0] !== 1'b1) begin bad++; $display("FAIL midrst_vld2 got=%b exp=1", o_vld[0]); end
      repeat (3) tick();
      total++; if (seen.size() !== 1) begin bad++; $display("FAIL midrst_words got=%0d exp=1", seen.size()); end
   endtask

   task automatic test_back_to_back();
      rdy = 1'b1;
      repeat (2) tick();
      seen.delete();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      repeat (3) tick();
      total++;
      if (seen.size() !== 2) begin
         bad++; $display("FAIL b2b_count got=%0d exp=2", seen.size());
      end else begin
         total++; if (seen[0][DW-1:0] !== 8'h00) begin bad++; $display("FAIL b2b_w0 got=%h exp=00", seen[0][DW-1:0]); end
         total++; if (seen[1][DW-1:0] !== 8'hFF) begin bad++; $display("FAIL b2b_w1 got=%h exp=ff", seen[1][DW-1:0]); end
         total++; if (seen[0][DW+1] !== 1'b0) begin bad++; $display("FAIL b2b_perr0 got=%b exp=0", seen[0][DW+1]); end
         total++; if (seen[1][DW+1] !== 1'b0) begin bad++; $display("FAIL b2b_perr1 got=%b exp=0", seen[1][DW+1]); end
      end
   endtask

   task automatic test_random();
      do_reset();
      drv_done = 1'b0;
      rnd_rdy  = 1'b1;
      fork
         begin
            for (int f = 0; f < 60; f++) begin
               int gap;
               gap = $urandom_range(0, 3);
               for (int g = 0; g < gap; g++) begin
                  if ($urandom_range(0, 1) == 1) drive_bit(1'b1);
                  else tick();
               end
               send_frame(DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
            end
            repeat (3) tick();
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(negedge clk);
               for (int k = 0; k < 2; k++) begin
                  total++; if (o_vld[k] !== m_vld[k]) begin bad++; $display("FAIL rnd_vld dut%0d t=%0t got=%b exp=%b", k, $time, o_vld[k], m_vld[k]); end
                  total++; if (o_dat[k] !== m_dat[k]) begin bad++; $display("FAIL rnd_dat dut%0d t=%0t got=%h exp=%h", k, $time, o_dat[k], m_dat[k]); end
                  total++; if (o_perr[k] !== m_perr[k]) begin bad++; $display("FAIL rnd_perr dut%0d t=%0t got=%b exp=%b", k, $time, o_perr[k], m_perr[k]); end
                  total++; if (o_ferr[k] !== m_ferr[k]) begin bad++; $display("FAIL rnd_ferr dut%0d t=%0t got=%b exp=%b", k, $time, o_ferr[k], m_ferr[k]); end
                  total++; if (o_ovr[k] !== m_ovr[k]) begin bad++; $display("FAIL rnd_ovr dut%0d t=%0t got=%b exp=%b", k, $time, o_ovr[k], m_ovr[k]); end
               end
            end
         end
      join
      rnd_rdy = 1'b0;
      rdy     = 1'b1;
   endtask

   initial begin
      test_reset();
      test_even_frame();
      test_parity();
      test_frame_err();
      test_overrun();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter ODD_PARITY, default 0, meaning: 0 = even parity expected, 1 = odd parity expected.
REQ-002 Parameter DATA_W, default 8, meaning: data bits per frame, range 1..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 bit_valid  input  1  strobe: bit_in is sampled on this cycle only.
REQ-006 bit_in  input  1  serial line bit.
REQ-007 out_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-008 data_out  output  DATA_W  received data word, LSB = first data bit received.
REQ-009 data_valid  output  1  data_out/parity_err/frame_err hold a completed frame.
REQ-010 parity_err  output  1  completed frame failed the parity check.
REQ-011 frame_err  output  1  completed frame had stop bit = 0.
REQ-012 overrun  output  1  sticky: a completed frame was dropped because the holding register was full.

Function
REQ-013 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, 1 parity bit, stop bit 1; one bit per bit_valid cycle.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP; cycles with bit_valid low SHALL not change state or counters.
REQ-015 IDLE: bit_valid with bit_in=0 SHALL go to DATA and clear the bit counter and running parity; bit_in=1 SHALL stay in IDLE.
REQ-016 DATA: each valid bit SHALL shift into the shift register and XOR into the running parity; after the DATA_W-th bit SHALL go to PARITY.
REQ-017 PARITY: the valid bit SHALL be XORed into the running parity; parity is good when the result equals ODD_PARITY; SHALL go to STOP.
REQ-018 STOP: the valid bit SHALL complete the frame, frame_err = ~bit_in, and the FSM SHALL return to IDLE.
REQ-019 A STOP bit of 0 SHALL NOT be treated as a new start bit; the next start bit is only recognised in IDLE.
REQ-020 On frame completion with data_valid=0, or with data_valid=1 and out_ready=1 in the same cycle, data_out/parity_err/frame_err SHALL load on that edge and data_valid SHALL be 1 on the following cycle (1-cycle latency from the stop bit).
REQ-021 On frame completion with data_valid=1 and out_ready=0, the new frame SHALL be discarded, the held word SHALL be unchanged, and overrun SHALL be set.
REQ-022 data_valid SHALL clear on the edge where data_valid=1 and out_ready=1, unless REQ-020 reloads it in that same cycle.
REQ-023 data_out, parity_err and frame_err SHALL be stable while data_valid=1 and out_ready=0.
REQ-024 overrun SHALL clear only on reset.
REQ-025 The receiver SHALL accept back-to-back frames, including a bit_valid on every cycle.

Reset
REQ-026 With rst_n=0 at a rising clk edge: FSM -> IDLE, counters and parity cleared, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame with no output; the first bit after reset SHALL be treated as in IDLE.

Structure
REQ-028 The FSM state encoding and the frame field widths SHALL live in the shared package serial_pkg, so the matching transmitter reuses them.
REQ-029 The running parity SHALL use a sub-module parity_acc: a 1-bit XOR accumulator with clear and enable, built from the team's gate-level xor.
REQ-030 The RTL SHALL contain no combinational path from bit_in to any output.

Verification
REQ-031 Even-parity frame 0,0xA5 LSB-first,0,1 (ODD_PARITY=0) -> data_out=0xA5, data_valid=1 one cycle after the stop bit, parity_err=0, frame_err=0.
REQ-032 Same frame with parity bit 1 -> data_out=0xA5, parity_err=1; with ODD_PARITY=1 and parity bit 1 -> parity_err=0.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err=1; a following idle 1 and then a valid frame 0x01 -> data_out=0x01, frame_err=0.
REQ-034 Two frames (0x11 then 0x22) with out_ready=0 throughout -> data_out stays 0x11, overrun=1; after out_ready=1 for one cycle -> data_valid=0.
REQ-035 rst_n=0 after the 4th data bit of frame 0xFF, then a full frame 0x5A -> data_out=0x5A; no output for the aborted frame.
REQ-036 Frames 0x00 and 0xFF sent back-to-back with bit_valid=1 every cycle and out_ready=1 -> two valid words 0x00, 0xFF with parity_err=0.
